// File: rtl/store_buffer.sv
// Store buffer between MEM and data memory: in-order FIFO drain, word-granular load aliasing.
// Optional store-to-load forwarding of youngest full-word entry when STORE_BUF_FWD_EN is defined.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_wd,
    input  logic [1:0]               st_len,
    input  logic [31:0]              st_pc,
    output logic                     st_err,
    input  logic                     dm_busy,
    output logic                     dm_we,
    output logic [ADDR_W-1:0]        dm_addr,
    output logic [31:0]              dm_wd,
    output logic [1:0]               dm_len,
    output logic [31:0]              dm_pc,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [1:0]               ld_len,
    output logic                     ld_hit,
    output logic                     ld_fwd_valid,
    output logic [31:0]              ld_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wd;
        logic [1:0]        len;
        logic [31:0]       pc;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;
    logic          st_err_q;

    logic legal, push, pop;

    always_comb begin
        legal = 1'b0;
        case (st_len)
            2'd0:    legal = (st_addr[1:0] == 2'b00);
            2'd1:    legal = !st_addr[0];
            2'd2:    legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign st_ready = (count_q < FULL);
    assign dm_we    = (count_q != '0) && !dm_busy;
    assign push     = st_valid && st_ready && legal;
    assign pop      = dm_we;

    assign dm_addr = mem_q[head_q].addr;
    assign dm_wd   = mem_q[head_q].wd;
    assign dm_len  = mem_q[head_q].len;
    assign dm_pc   = mem_q[head_q].pc;
    assign count   = count_q;
    assign st_err  = st_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= st_valid && st_ready && !legal;
            if (push) begin
                mem_q[tail_q] <= '{addr: st_addr, wd: st_wd, len: st_len, pc: st_pc};
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk from head to tail so the last match seen is the youngest store.
    logic          hit_any;
    logic [1:0]    match_len;
    logic [31:0]   match_wd;
    logic [PW-1:0] idx;

    always_comb begin
        hit_any   = 1'b0;
        match_len = '0;
        match_wd  = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) &&
                (mem_q[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
                hit_any   = 1'b1;
                match_len = mem_q[idx].len;
                match_wd  = mem_q[idx].wd;
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic        fwd_ok;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        fwd_ok       = ld_valid && hit_any && (match_len == 2'd0) && (ld_len != 2'd3);
        half_sel     = ld_addr[1] ? match_wd[31:16] : match_wd[15:0];
        byte_sel     = match_wd[8*ld_addr[1:0] +: 8];
        ld_hit       = ld_valid && hit_any && !fwd_ok;
        ld_fwd_valid = fwd_ok;
        ld_fwd_data  = '0;
        if (fwd_ok) begin
            case (ld_len)
                2'd0:    ld_fwd_data = match_wd;
                2'd1:    ld_fwd_data = {{16{half_sel[15]}}, half_sel};
                default: ld_fwd_data = {{24{byte_sel[7]}}, byte_sel};
            endcase
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd   = ^{ld_len, ld_addr[1:0], match_len, match_wd};
    assign ld_hit       = ld_valid && hit_any;
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed table, hand sequences, and randomized run against a queue model.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              st_valid, st_ready, st_err;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wd, st_pc;
    logic [1:0]        st_len;
    logic              dm_busy, dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd, dm_pc;
    logic [1:0]        dm_len;
    logic              ld_valid, ld_hit, ld_fwd_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_len;
    logic [31:0]       ld_fwd_data;
    logic [2:0]        count;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_wd(st_wd),
        .st_len(st_len), .st_pc(st_pc), .st_err(st_err),
        .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_len(dm_len), .dm_pc(dm_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_len(ld_len), .ld_hit(ld_hit),
        .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [13:0] addr;
        logic [31:0] wd;
        logic [1:0]  len;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    bit   exp_err = 0;

    function automatic bit is_legal(logic [1:0] len, logic [13:0] a);
        case (len)
            2'd0:    return a[1:0] == 2'b00;
            2'd1:    return a[0] == 1'b0;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sext_sel(logic [31:0] w, logic [1:0] len, logic [1:0] lo);
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? w[31:16] : w[15:0];
        b = 8'((w >> (8 * lo)) & 32'hFF);
        case (len)
            2'd0:    return w;
            2'd1:    return 32'($signed(h));
            default: return 32'($signed(b));
        endcase
    endfunction

    task automatic check_comb();
        bit exp_hit, exp_fv;
        logic [31:0] exp_fd;
        int youngest;
        chk("st_ready", st_ready, q.size() < DEPTH);
        chk("dm_we", dm_we, (q.size() != 0) && !dm_busy);
        if (q.size() != 0) begin
            chk("dm_addr", dm_addr, q[0].addr);
            chk("dm_wd", dm_wd, q[0].wd);
            chk("dm_len", dm_len, q[0].len);
            chk("dm_pc", dm_pc, q[0].pc);
        end
        youngest = -1;
        foreach (q[i]) if ((q[i].addr >> 2) == (ld_addr >> 2)) youngest = i;
        exp_hit = ld_valid && (youngest >= 0);
        exp_fv  = 1'b0;
        exp_fd  = '0;
`ifdef STORE_BUF_FWD_EN
        if (exp_hit && q[youngest].len == 2'd0 && ld_len != 2'd3) begin
            exp_fv  = 1'b1;
            exp_hit = 1'b0;
            exp_fd  = sext_sel(q[youngest].wd, ld_len, ld_addr[1:0]);
        end
`endif
        chk("ld_hit", ld_hit, exp_hit);
        chk("ld_fwd_valid", ld_fwd_valid, exp_fv);
`ifdef STORE_BUF_FWD_EN
        if (exp_fv) chk("ld_fwd_data", ld_fwd_data, exp_fd);
`else
        chk("ld_fwd_data", ld_fwd_data, exp_fd);
`endif
    endtask

    task automatic tick();
        bit we, rdy;
        check_comb();
        we  = (q.size() != 0) && !dm_busy;
        rdy = q.size() < DEPTH;
        @(posedge clk);
        exp_err = 0;
        if (we) void'(q.pop_front());
        if (st_valid && rdy) begin
            if (is_legal(st_len, st_addr))
                q.push_back('{addr: st_addr, wd: st_wd, len: st_len, pc: st_pc});
            else
                exp_err = 1;
        end
        #1;
        chk("count", count, q.size());
        chk("st_err", st_err, exp_err);
    endtask

    task automatic drive(input bit sv, input logic [13:0] sa, input logic [31:0] sw,
                         input logic [1:0] sl, input bit busy,
                         input bit lv, input logic [13:0] la, input logic [1:0] ll);
        st_valid = sv; st_addr = sa; st_wd = sw; st_len = sl; st_pc = 32'h1000 + 32'(sa);
        dm_busy = busy; ld_valid = lv; ld_addr = la; ld_len = ll;
    endtask

    typedef struct {
        bit sv; logic [13:0] sa; logic [31:0] sw; logic [1:0] sl; bit busy;
        bit lv; logic [13:0] la; logic [1:0] ll;
        bit e_ready; bit e_we; logic [13:0] e_addr; logic [31:0] e_wd; bit e_hit;
        int e_count; bit e_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 14'h0010, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 14'h0010, 32'h12345678, 0, 0, 0};
        vecs[2] = '{1, 14'h0021, 32'h00001234, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[3] = '{1, 14'h0022, 32'h5555AAAA, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{1, 14'h0033, 32'hAA000000, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[6] = '{0, 0, 0, 0, 1, 1, 14'h0030, 0, 1, 0, 0, 0, 1, 1, 0};
        vecs[7] = '{0, 0, 0, 0, 1, 1, 14'h0034, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 14'h0033, 32'hAA000000, 0, 0, 0};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset count", count, 0);
        chk("reset st_err", st_err, 0);
        chk("reset dm_we", dm_we, 0);
        chk("reset st_ready", st_ready, 1);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].sv, vecs[i].sa, vecs[i].sw, vecs[i].sl, vecs[i].busy,
                  vecs[i].lv, vecs[i].la, vecs[i].ll);
            #1;
            chk($sformatf("vec%0d st_ready", i), st_ready, vecs[i].e_ready);
            chk($sformatf("vec%0d dm_we", i), dm_we, vecs[i].e_we);
            if (vecs[i].e_we) begin
                chk($sformatf("vec%0d dm_addr", i), dm_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d dm_wd", i), dm_wd, vecs[i].e_wd);
            end
            chk($sformatf("vec%0d ld_hit", i), ld_hit, vecs[i].e_hit);
            tick();
            chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d st_err", i), st_err, vecs[i].e_err);
        end

        // Fill with DM busy, fifth store must be held off, then drain in order.
        for (int k = 0; k < 5; k++) begin
            drive(1, 14'(14'h100 + 4 * k), 32'hC0DE0000 + 32'(k), 0, 1, 0, 0, 0);
            #1;
            if (k == 4) chk("full st_ready", st_ready, 0);
            tick();
        end
        chk("full count", count, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain dm_we", dm_we, 1);
            chk("drain dm_addr", dm_addr, 14'(14'h100 + 4 * k));
            chk("drain dm_wd", dm_wd, 32'hC0DE0000 + 32'(k));
            tick();
        end
        chk("drained count", count, 0);

`ifdef STORE_BUF_FWD_EN
        drive(1, 14'h0040, 32'h80FF7F01, 0, 1, 0, 0, 0);
        #1; tick();
        drive(0, 0, 0, 0, 1, 1, 14'h0042, 2);
        #1;
        chk("fwd byte valid", ld_fwd_valid, 1);
        chk("fwd byte data", ld_fwd_data, 32'hFFFFFFFF);
        chk("fwd byte hit", ld_hit, 0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 14'h0040, 1);
        #1;
        chk("fwd half valid", ld_fwd_valid, 1);
        chk("fwd half data", ld_fwd_data, 32'h00007F01);
        chk("fwd half hit", ld_hit, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1; tick();
`endif

        // Asynchronous reset mid-cycle with two pending stores.
        for (int k = 0; k < 2; k++) begin
            drive(1, 14'(14'h200 + 4 * k), 32'hBEEF0000 + 32'(k), 0, 1, 0, 0, 0);
            #1; tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre-reset count", count, 2);
        #2 rst = 1'b0;
        #1;
        chk("async reset count", count, 0);
        chk("async reset dm_we", dm_we, 0);
        q.delete();
        exp_err = 0;
        @(posedge clk); #1;
        chk("in reset dm_we", dm_we, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post reset dm_we", dm_we, 0);
            tick();
        end

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            bit lv;
            lv = ($urandom_range(0, 2) == 0);
            drive(!lv && ($urandom_range(0, 1) == 1),
                  14'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3)),
                  $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0),
                  lv, 14'(($urandom_range(0, 6) << 2) | $urandom_range(0, 3)),
                  2'($urandom_range(0, 2)));
            #1; tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
